// File: rtl/matrix_scan_driver.sv
// rtl/matrix_scan_driver.sv - row-multiplexed 10x10 LED matrix scan driver with double-buffered frame
//
// Ports:
//   clock        in   system clock, rising edge
//   restart_n    in   asynchronous active-low reset
//   enable       in   1 = scan running, 0 = dark and idle
//   frame_valid  in   one-cycle strobe capturing leds into the pending buffer
//   leds         in   ROWS*COLS frame image, row r at leds[r*COLS +: COLS]
//   brightness   in   4-bit PWM duty (only when MATRIX_SCAN_PWM_EN is defined)
//   row_sel      out  one-hot row drive, active high
//   col_data     out  column drive for the selected row, active high
//   frame_done   out  one-cycle pulse after the last row's dwell ends
//   busy         out  1 whenever the scan is not idle
//
// Optional feature macro: MATRIX_SCAN_PWM_EN (adds brightness PWM gating of col_data).

module matrix_scan_driver #(
    parameter int ROWS         = 10,
    parameter int COLS         = 10,
    parameter int DWELL_CYCLES = 5000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 restart_n,
    input  logic                 enable,
    input  logic                 frame_valid,
    input  logic [ROWS*COLS-1:0] leds,
`ifdef MATRIX_SCAN_PWM_EN
    input  logic [3:0]           brightness,
`endif
    output logic [ROWS-1:0]      row_sel,
    output logic [COLS-1:0]      col_data,
    output logic                 frame_done,
    output logic                 busy
);

    localparam int CNT_MAX = ((DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES) - 1;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ROWS*COLS-1:0]   shadow_q, shadow_d;
    logic [ROWS*COLS-1:0]   pending_q, pending_d;
    logic                   pend_flag_q, pend_flag_d;
    logic [ROWS-1:0]        row_sel_q, row_sel_d;
    logic [COLS-1:0]        col_data_q, col_data_d;
    logic                   frame_done_q, frame_done_d;
    logic                   busy_q, busy_d;
    logic                   boundary;
    logic [ROWS-1:0]        row_oh;
    logic [COLS-1:0]        row_bits;
`ifdef MATRIX_SCAN_PWM_EN
    logic [3:0]             pwm_q, pwm_d;
    logic                   pwm_on;
`endif

    // Sequencer: IDLE -> (BLANK -> DRIVE) per row, wrapping after the last row.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;
        boundary     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                row_d = '0;
                cnt_d = '0;
                if (enable) begin
                    state_d  = ST_BLANK;
                    boundary = 1'b1;
                end
            end
            ST_BLANK: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    row_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == BLANK_LAST) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DRIVE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    row_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == DWELL_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    if (row_q == ROW_LAST) begin
                        row_d        = '0;
                        frame_done_d = 1'b1;
                        boundary     = 1'b1;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                row_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Double buffer: shadow only changes at a frame boundary so a frame is never torn.
    // A strobe coinciding with the boundary bypasses pending and lands in shadow directly.
    always_comb begin
        pending_d   = pending_q;
        pend_flag_d = pend_flag_q;
        shadow_d    = shadow_q;
        if (frame_valid) begin
            pending_d = leds;
        end
        if (boundary) begin
            if (frame_valid) begin
                shadow_d    = leds;
                pend_flag_d = 1'b0;
            end else if (pend_flag_q) begin
                shadow_d    = pending_q;
                pend_flag_d = 1'b0;
            end
        end else if (frame_valid) begin
            pend_flag_d = 1'b1;
        end
    end

    // Outputs are registered, so they are computed from the next state/row.
    // Shadow never changes on an edge that enters DRIVE, so shadow_q is safe here.
    always_comb begin
        row_oh   = '0;
        row_bits = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_d == ROW_W'(r)) begin
                row_oh[r] = 1'b1;
                row_bits  = shadow_q[r*COLS +: COLS];
            end
        end
    end

`ifdef MATRIX_SCAN_PWM_EN
    always_comb begin
        pwm_d  = (state_d == ST_DRIVE && state_q == ST_DRIVE) ? pwm_q + 4'd1 : 4'd0;
        pwm_on = (pwm_d < brightness);
    end
`endif

    always_comb begin
        busy_d     = (state_d != ST_IDLE);
        row_sel_d  = '0;
        col_data_d = '0;
        if (state_d == ST_DRIVE) begin
            row_sel_d = row_oh;
`ifdef MATRIX_SCAN_PWM_EN
            col_data_d = row_bits & {COLS{pwm_on}};
`else
            col_data_d = row_bits;
`endif
        end
    end

    always_ff @(posedge clock or negedge restart_n) begin
        if (!restart_n) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            cnt_q        <= '0;
            shadow_q     <= '0;
            pending_q    <= '0;
            pend_flag_q  <= 1'b0;
            row_sel_q    <= '0;
            col_data_q   <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef MATRIX_SCAN_PWM_EN
            pwm_q        <= 4'd0;
`endif
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            pend_flag_q  <= pend_flag_d;
            row_sel_q    <= row_sel_d;
            col_data_q   <= col_data_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
`ifdef MATRIX_SCAN_PWM_EN
            pwm_q        <= pwm_d;
`endif
        end
    end

    assign row_sel    = row_sel_q;
    assign col_data   = col_data_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// tb/tb_matrix_scan_driver.sv - directed self-checking bench for matrix_scan_driver

module tb_matrix_scan_driver;

    logic         clock;
    logic         restart_n;
    logic         enable;
    logic         frame_valid;
    logic [99:0]  leds;
    logic [9:0]   row_sel;
    logic [9:0]   col_data;
    logic         frame_done;
    logic         busy;

    int errors = 0;
    int checks = 0;

    matrix_scan_driver #(
        .ROWS(10), .COLS(10), .DWELL_CYCLES(4), .BLANK_CYCLES(2)
    ) dut (
        .clock(clock), .restart_n(restart_n), .enable(enable),
        .frame_valid(frame_valid), .leds(leds),
        .row_sel(row_sel), .col_data(col_data),
        .frame_done(frame_done), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Expected scan outputs k edges after enable is first sampled high.
    // Each row occupies 6 edges: 2 blank then 4 drive; frames are 60 edges.
    // Shadow holds leds=1 for frames 0..1 and all ones from frame 2 on.
    task automatic expect_at(input int k, output logic [9:0] rs, output logic [9:0] cd,
                             output logic [9:0] fd);
        int p, f, r, w;
        p  = (k - 1) % 60;
        f  = (k - 1) / 60;
        r  = p / 6;
        w  = p % 6;
        rs = 10'h000;
        cd = 10'h000;
        fd = (p == 0 && k > 1) ? 10'h001 : 10'h000;
        if (w >= 2) begin
            rs = 10'h001 << r;
            if (f >= 2)      cd = 10'h3FF;
            else if (r == 0) cd = 10'h001;
        end
    endtask

    initial begin
        logic [9:0] e_rs, e_cd, e_fd;

        restart_n   = 1'b0;
        enable      = 1'b0;
        frame_valid = 1'b0;
        leds        = '0;
        #23;
        chk("reset_row_sel",    row_sel,           10'h000);
        chk("reset_col_data",   col_data,          10'h000);
        chk("reset_frame_done", {9'd0, frame_done}, 10'h000);
        chk("reset_busy",       {9'd0, busy},       10'h000);

        @(negedge clock);
        restart_n = 1'b1;

        // Capture leds=1 into pending while idle.
        frame_valid = 1'b1;
        leds        = 100'h1;
        step();
        frame_valid = 1'b0;
        leds        = '0;
        chk("idle_busy",    {9'd0, busy}, 10'h000);
        chk("idle_row_sel", row_sel,      10'h000);

        enable = 1'b1;
        step();
        chk("edge1_busy", {9'd0, busy}, 10'h001);
        chk("edge1_row_sel", row_sel, 10'h000);
        step();
        chk("edge2_row_sel", row_sel, 10'h000);
        step();
        chk("edge3_row_sel", row_sel, 10'h001);
        chk("edge3_col_data", col_data, 10'h001);

        // Full-scan run with the model; update mid-frame 1 at row 4 (edge 87).
        for (int k = 4; k <= 219; k++) begin
            step();
            expect_at(k, e_rs, e_cd, e_fd);
            chk($sformatf("scan_row_sel_k%0d", k),    row_sel,            e_rs);
            chk($sformatf("scan_col_data_k%0d", k),   col_data,           e_cd);
            chk($sformatf("scan_frame_done_k%0d", k), {9'd0, frame_done}, e_fd);
            if (k == 86) begin
                frame_valid = 1'b1;
                leds        = {100{1'b1}};
            end
            if (k == 87) begin
                frame_valid = 1'b0;
                leds        = '0;
            end
        end

        // k=219 is the first drive cycle of row 6 in frame 3: drop enable.
        enable = 1'b0;
        step();
        chk("disable_row_sel",    row_sel,            10'h000);
        chk("disable_col_data",   col_data,           10'h000);
        chk("disable_busy",       {9'd0, busy},       10'h000);
        chk("disable_frame_done", {9'd0, frame_done}, 10'h000);
        step();
        chk("idle2_row_sel", row_sel, 10'h000);
        chk("idle2_busy", {9'd0, busy}, 10'h000);

        // Re-enable: restarts at row 0 after two blank cycles, shadow kept.
        enable = 1'b1;
        step();
        chk("reen1_row_sel", row_sel, 10'h000);
        chk("reen1_busy", {9'd0, busy}, 10'h001);
        step();
        chk("reen2_row_sel", row_sel, 10'h000);
        step();
        chk("reen3_row_sel", row_sel, 10'h001);
        chk("reen3_col_data", col_data, 10'h3FF);

        // Asynchronous reset in the middle of DRIVE.
        #3;
        restart_n = 1'b0;
        #1;
        chk("areset_row_sel",    row_sel,            10'h000);
        chk("areset_col_data",   col_data,           10'h000);
        chk("areset_busy",       {9'd0, busy},       10'h000);
        chk("areset_frame_done", {9'd0, frame_done}, 10'h000);

        // Shadow must now be clear: row 0 drives with dark columns.
        @(negedge clock);
        restart_n = 1'b1;
        step();
        step();
        chk("post_reset_edge2_row_sel", row_sel, 10'h000);
        step();
        chk("post_reset_row_sel", row_sel, 10'h001);
        chk("post_reset_col_data", col_data, 10'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
